// File: rtl/hit_event_fifo_if.sv
// Bus-side bundle for hit_event_fifo: frame classification in, FWFT event queue out.
// master = detector/CPU side that drives frames and pops; slave = the FIFO block.
interface hit_event_fifo_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          advance;
   logic [2:0]    overall_result;
   logic          rd_en;
   logic [31:0]   rd_data;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clear_overflow;

   modport master (
      output advance, overall_result, rd_en, clear_overflow,
      input  rd_data, empty, count, overflow
   );

   modport slave (
      input  advance, overall_result, rd_en, clear_overflow,
      output rd_data, empty, count, overflow
   );
endinterface

// File: rtl/hit_event_fifo.sv
// Turns per-frame note classifications into debounced, held-off hit events
// stamped with a frame count, queued in a first-word-fall-through FIFO.
module hit_event_fifo #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TS_WIDTH = 24,
   parameter int unsigned MIN_ON   = 2,
   parameter int unsigned HOLDOFF  = 32
) (
   input  logic             clk,
   input  logic             reset,
   hit_event_fifo_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned RW = $clog2(MIN_ON + 1);
   localparam int unsigned HW = $clog2(HOLDOFF + 1);
   localparam int unsigned DW = TS_WIDTH + 3;
   localparam bit          ONE_SHOT = (MIN_ON == 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CAND = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                r_state;
   logic [TS_WIDTH-1:0]   r_ts;
   logic [2:0]            r_cand_note;
   logic [TS_WIDTH-1:0]   r_cand_ts;
   logic [RW-1:0]         r_run;
   logic [HW-1:0]         r_holdoff;

   logic [DW-1:0]         r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_empty;
   logic [31:0]           r_rd_data;
   logic                  r_overflow;

   logic                  w_note_valid;
   logic                  w_same_note;
   logic                  w_ev_push;
   logic [DW-1:0]         w_ev_data;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_wr;
   logic                  w_drop;
   logic [AW-1:0]         w_rd_ptr_nxt;
   logic [CW-1:0]         w_count_nxt;
   logic [DW-1:0]         w_head_nxt;

   // Codes 5-7 are treated as silence.
   assign w_note_valid = (bus.overall_result != 3'd0) && (bus.overall_result <= 3'd4);
   assign w_same_note  = (bus.overall_result == r_cand_note);

   // Qualifying onset: raised on the advance cycle that completes the run.
   always_comb begin
      w_ev_push = 1'b0;
      w_ev_data = {r_cand_note, r_cand_ts};
      if (bus.advance && w_note_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (ONE_SHOT) begin
                  w_ev_push = 1'b1;
                  w_ev_data = {bus.overall_result, r_ts};
               end
            end
            ST_CAND: begin
               if (w_same_note && (r_run == RW'(MIN_ON - 1))) begin
                  w_ev_push = 1'b1;
               end
            end
            default: w_ev_push = 1'b0;
         endcase
      end
   end

   // Onset qualifier and hold-off/re-arm state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ts        <= '0;
         r_cand_note <= '0;
         r_cand_ts   <= '0;
         r_run       <= '0;
         r_holdoff   <= '0;
      end else if (bus.advance) begin
         r_ts <= r_ts + TS_WIDTH'(1);
         case (r_state)
            ST_IDLE: begin
               if (w_note_valid) begin
                  r_cand_note <= bus.overall_result;
                  r_cand_ts   <= r_ts;
                  r_run       <= RW'(1);
                  if (ONE_SHOT) begin
                     r_state   <= ST_HOLD;
                     r_holdoff <= HW'(HOLDOFF);
                  end else begin
                     r_state   <= ST_CAND;
                  end
               end
            end
            ST_CAND: begin
               if (!w_note_valid) begin
                  r_state <= ST_IDLE;
               end else if (!w_same_note) begin
                  r_cand_note <= bus.overall_result;
                  r_cand_ts   <= r_ts;
                  r_run       <= RW'(1);
               end else if (w_ev_push) begin
                  r_state   <= ST_HOLD;
                  r_holdoff <= HW'(HOLDOFF);
               end else begin
                  r_run <= r_run + RW'(1);
               end
            end
            ST_HOLD: begin
               // Re-arm looks at the pre-decrement value and needs silence.
               if (r_holdoff != '0) begin
                  r_holdoff <= r_holdoff - HW'(1);
               end else if (!w_note_valid) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_pop        = bus.rd_en && !r_empty;
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_wr         = w_ev_push && (!w_full || w_pop);
   assign w_drop       = w_ev_push && w_full && !w_pop;
   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
   assign w_count_nxt  = r_count + CW'(w_wr) - CW'(w_pop);

   // Next head: a write into the head slot bypasses the memory.
   always_comb begin
      w_head_nxt = '0;
      if (w_count_nxt != '0) begin
         if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_ev_data;
         end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= w_ev_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_empty    <= 1'b1;
         r_rd_data  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_count   <= w_count_nxt;
         r_empty   <= (w_count_nxt == '0);
         r_rd_data <= 32'(w_head_nxt);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.clear_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign bus.rd_data  = r_rd_data;
   assign bus.empty    = r_empty;
   assign bus.count    = r_count;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_hit_event_fifo.sv
// Scoreboard bench for hit_event_fifo: directed frame sequences push expected
// events; negedge monitors pop and compare whenever an entry is read out.
module tb_hit_event_fifo;
   logic clk = 1'b0;
   logic reset;
   logic reset2;
   always #5 clk = ~clk;

   hit_event_fifo_if #(.DEPTH(16)) bus1 ();
   hit_event_fifo_if #(.DEPTH(4))  bus2 ();

   hit_event_fifo #(.DEPTH(16), .TS_WIDTH(24), .MIN_ON(2), .HOLDOFF(32)) dut (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   // Narrow timestamp, single-frame onset, minimal hold-off: exercises wrap.
   hit_event_fifo #(.DEPTH(4), .TS_WIDTH(8), .MIN_ON(1), .HOLDOFF(1)) dut2 (
      .clk(clk), .reset(reset2), .bus(bus2)
   );

   int total = 0;
   int bad   = 0;
   int ts_m  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp2_q[$];

   function automatic logic [31:0] ev24(input logic [2:0] n, input int t);
      return {5'd0, n, 24'(t)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, want);
      end
   endtask

   task automatic sb_pop(input string name, inout logic [31:0] q[$], input logic [31:0] act);
      logic [31:0] e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL %s: popped 0x%08h but no entry expected", name, act);
      end else begin
         e = q.pop_front();
         if (act !== e) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus1.rd_en && !bus1.empty) sb_pop("sb_head", exp_q, bus1.rd_data);
   end

   always @(negedge clk) begin
      if (!reset2 && bus2.rd_en && !bus2.empty) sb_pop("sb2_head", exp2_q, bus2.rd_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [2:0] r);
      bus1.advance = 1'b1;
      bus1.overall_result = r;
      tick();
      bus1.advance = 1'b0;
      bus1.overall_result = 3'd0;
      ts_m++;
   endtask

   task automatic frame2(input logic [2:0] r);
      bus2.advance = 1'b1;
      bus2.overall_result = r;
      tick();
      bus2.advance = 1'b0;
      bus2.overall_result = 3'd0;
   endtask

   task automatic rst1();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ts_m = 0;
      exp_q.delete();
   endtask

   task automatic pop1();
      bus1.rd_en = 1'b1;
      tick();
      bus1.rd_en = 1'b0;
   endtask

   task automatic pop2();
      bus2.rd_en = 1'b1;
      tick();
      bus2.rd_en = 1'b0;
   endtask

   // Two-frame onset then enough silence to re-arm. mode 1: pop on the push
   // cycle, mode 2: clear_overflow on the push cycle.
   task automatic hit(input logic [2:0] n, input int mode, input bit store);
      if (store) exp_q.push_back(ev24(n, ts_m));
      frame(n);
      bus1.rd_en          = (mode == 1);
      bus1.clear_overflow = (mode == 2);
      frame(n);
      bus1.rd_en          = 1'b0;
      bus1.clear_overflow = 1'b0;
      repeat (33) frame(3'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus1.advance = 1'b0; bus1.overall_result = 3'd0; bus1.rd_en = 1'b0; bus1.clear_overflow = 1'b0;
      bus2.advance = 1'b0; bus2.overall_result = 3'd0; bus2.rd_en = 1'b0; bus2.clear_overflow = 1'b0;
      reset  = 1'b1;
      reset2 = 1'b1;
      tick();
      reset  = 1'b0;
      reset2 = 1'b0;
      ts_m   = 0;

      chk("rst_count", 32'(bus1.count), 32'd0);
      chk("rst_empty", 32'(bus1.empty), 32'd1);
      chk("rst_rd_data", bus1.rd_data, 32'd0);
      chk("rst_overflow", 32'(bus1.overflow), 32'd0);

      // Debounce: 0,3,3,0 -> one event note 3 ts 1
      frame(3'd0);
      frame(3'd3);
      chk("t1_empty_before", 32'(bus1.empty), 32'd1);
      exp_q.push_back(32'h0300_0001);
      frame(3'd3);
      chk("t1_empty_after", 32'(bus1.empty), 32'd0);
      chk("t1_count", 32'(bus1.count), 32'd1);
      frame(3'd0);
      chk("t1_rd_data", bus1.rd_data, 32'h0300_0001);
      pop1();
      chk("t1_empty_popped", 32'(bus1.empty), 32'd1);

      // Candidate restart: 1,2,2 -> note 2 ts 1
      rst1();
      frame(3'd1);
      frame(3'd2);
      exp_q.push_back(32'h0200_0001);
      frame(3'd2);
      chk("t2_count", 32'(bus1.count), 32'd1);
      pop1();
      // Lone note then silence is not a hit; 1,2,2 at ts 3..5 gives note 2 ts 4
      rst1();
      frame(3'd4);
      frame(3'd0);
      frame(3'd0);
      chk("t2_lone_note", 32'(bus1.count), 32'd0);
      frame(3'd1);
      frame(3'd2);
      exp_q.push_back(32'h0200_0004);
      frame(3'd2);
      chk("t2_restart_count", 32'(bus1.count), 32'd1);
      pop1();

      // Hold-off: note 1 for 40 frames, silence at ts 40, re-onset ts 41
      rst1();
      exp_q.push_back(32'h0100_0000);
      repeat (40) frame(3'd1);
      frame(3'd0);
      exp_q.push_back(32'h0100_0029);
      frame(3'd1);
      frame(3'd1);
      chk("t3_two_events", 32'(bus1.count), 32'd2);
      pop1();
      pop1();
      chk("t3_drained", 32'(bus1.empty), 32'd1);
      // Early 0,1,1 ignored; silence at ts 33 still too early; re-arm at ts 36
      rst1();
      exp_q.push_back(32'h0100_0000);
      frame(3'd1);
      frame(3'd1);
      frame(3'd0);
      frame(3'd1);
      frame(3'd1);
      chk("t3_early_reonset", 32'(bus1.count), 32'd1);
      repeat (29) frame(3'd0);
      frame(3'd4);
      frame(3'd4);
      chk("t3_holdoff_edge", 32'(bus1.count), 32'd1);
      frame(3'd0);
      exp_q.push_back(32'h0400_0025);
      frame(3'd4);
      frame(3'd4);
      chk("t3_rearmed", 32'(bus1.count), 32'd2);
      pop1();
      pop1();

      // FWFT ordering with back-to-back pops
      rst1();
      hit(3'd1, 0, 1'b1);
      hit(3'd2, 0, 1'b1);
      hit(3'd3, 0, 1'b1);
      chk("t4_count3", 32'(bus1.count), 32'd3);
      bus1.rd_en = 1'b1;
      tick();
      chk("t4_count2", 32'(bus1.count), 32'd2);
      tick();
      chk("t4_count1", 32'(bus1.count), 32'd1);
      tick();
      chk("t4_count0", 32'(bus1.count), 32'd0);
      bus1.rd_en = 1'b0;
      chk("t4_empty", 32'(bus1.empty), 32'd1);
      chk("t4_rd_data_zero", bus1.rd_data, 32'd0);
      pop1();
      chk("t4_pop_empty", 32'(bus1.count), 32'd0);

      // Overflow, set-wins-over-clear, push+pop while full
      rst1();
      for (int i = 0; i < 16; i++) hit(3'((i % 4) + 1), 0, 1'b1);
      chk("t5_full_count", 32'(bus1.count), 32'd16);
      chk("t5_no_ovf_yet", 32'(bus1.overflow), 32'd0);
      hit(3'd1, 0, 1'b0);
      chk("t5_drop_count", 32'(bus1.count), 32'd16);
      chk("t5_ovf_set", 32'(bus1.overflow), 32'd1);
      chk("t5_head_kept", bus1.rd_data, 32'h0100_0000);
      bus1.clear_overflow = 1'b1;
      tick();
      bus1.clear_overflow = 1'b0;
      chk("t5_ovf_cleared", 32'(bus1.overflow), 32'd0);
      hit(3'd2, 2, 1'b0);
      chk("t5_set_wins", 32'(bus1.overflow), 32'd1);
      bus1.clear_overflow = 1'b1;
      tick();
      bus1.clear_overflow = 1'b0;
      hit(3'd3, 1, 1'b1);
      chk("t5_pushpop_count", 32'(bus1.count), 32'd16);
      chk("t5_pushpop_ovf", 32'(bus1.overflow), 32'd0);
      repeat (16) pop1();
      chk("t5_drained", 32'(bus1.empty), 32'd1);

      // Reset while in CANDIDATE with 5 queued
      rst1();
      repeat (5) hit(3'd4, 0, 1'b1);
      frame(3'd2);
      chk("t6_pre_count", 32'(bus1.count), 32'd5);
      rst1();
      chk("t6_count", 32'(bus1.count), 32'd0);
      chk("t6_empty", 32'(bus1.empty), 32'd1);
      chk("t6_overflow", 32'(bus1.overflow), 32'd0);
      chk("t6_rd_data", bus1.rd_data, 32'd0);
      exp_q.push_back(32'h0300_0000);
      frame(3'd3);
      frame(3'd3);
      chk("t6_post_count", 32'(bus1.count), 32'd1);
      pop1();

      // Timestamp wrap on the 8-bit instance: hits at ts 255 and ts 2
      repeat (255) frame2(3'd0);
      exp2_q.push_back(32'h0000_02FF);
      frame2(3'd2);
      frame2(3'd0);
      frame2(3'd0);
      exp2_q.push_back(32'h0000_0302);
      frame2(3'd3);
      chk("wrap_count", 32'(bus2.count), 32'd2);
      pop2();
      pop2();
      chk("wrap_empty", 32'(bus2.empty), 32'd1);

      tick();
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      chk("sb2_leftover", 32'(exp2_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
